// File: rtl/vga_ctrl_pkg.sv
// Shared types for the VGA framebuffer write controller: coordinate widths,
// fill FSM states, arbiter grant ids and the pixel write payload.
package vga_ctrl_pkg;

    localparam int unsigned X_BITS     = 11;
    localparam int unsigned Y_BITS     = 11;
    localparam int unsigned COLOR_BITS = 2;
    localparam int unsigned HD         = 1280;
    localparam int unsigned VD         = 1024;

    typedef logic [X_BITS-1:0]     xcoord_t;
    typedef logic [Y_BITS-1:0]     ycoord_t;
    typedef logic [COLOR_BITS-1:0] color_t;

    typedef enum logic {IDLE, RUN} fill_state_t;

    typedef enum logic {GNT_HOST, GNT_FILL} gnt_id_t;

    typedef struct packed {
        xcoord_t x;
        ycoord_t y;
        color_t  color;
    } pixel_t;

    // Rectangle must be non-empty and lie inside the visible area.
    function automatic logic rect_legal(xcoord_t x0, xcoord_t x1, ycoord_t y0, ycoord_t y1);
        return (x0 <= x1) && (y0 <= y1) && (x1 < X_BITS'(HD)) && (y1 < Y_BITS'(VD));
    endfunction

endpackage

// File: rtl/vga_wr_arb.sv
// Two-requester round-robin arbiter feeding a single registered write slot
// with a valid/ready handshake towards the framebuffer.
module vga_wr_arb
    import vga_ctrl_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   host_req_i,
    input  pixel_t host_pix_i,
    input  logic   fill_req_i,
    input  pixel_t fill_pix_i,
    input  logic   fb_ready_i,
    output logic   host_gnt_c_o,
    output logic   fill_gnt_c_o,
    output pixel_t pix_o,
    output logic   we_o
);

    logic    we_q;
    pixel_t  pix_q;
    gnt_id_t last_q;

    logic can_load_c;
    logic host_win_c;
    logic fill_win_c;

    // On a tie the requester that did not win last time gets the slot.
    always_comb begin
        can_load_c = !we_q || fb_ready_i;
        host_win_c = can_load_c && !rst_i && host_req_i
                     && (!fill_req_i || (last_q == GNT_FILL));
        fill_win_c = can_load_c && !rst_i && fill_req_i && !host_win_c;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q   <= 1'b0;
            pix_q  <= '0;
            last_q <= GNT_FILL;
        end else if (host_win_c) begin
            we_q   <= 1'b1;
            pix_q  <= host_pix_i;
            last_q <= GNT_HOST;
        end else if (fill_win_c) begin
            we_q   <= 1'b1;
            pix_q  <= fill_pix_i;
            last_q <= GNT_FILL;
        end else if (can_load_c) begin
            we_q   <= 1'b0;
        end
    end

    assign host_gnt_c_o = host_win_c;
    assign fill_gnt_c_o = fill_win_c;
    assign pix_o        = pix_q;
    assign we_o         = we_q;

endmodule

// File: rtl/vga_fb_write_ctrl.sv
// Framebuffer write-side controller: shares the VGA write port between host
// single-pixel writes and a rectangle-fill engine.
module vga_fb_write_ctrl
    import vga_ctrl_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  host_req_i,
    input  logic [X_BITS-1:0]     host_x_i,
    input  logic [Y_BITS-1:0]     host_y_i,
    input  logic [COLOR_BITS-1:0] host_color_i,
    output logic                  host_ack_o,
    input  logic                  fill_start_i,
    input  logic                  fill_abort_i,
    input  logic [X_BITS-1:0]     fill_x0_i,
    input  logic [X_BITS-1:0]     fill_x1_i,
    input  logic [Y_BITS-1:0]     fill_y0_i,
    input  logic [Y_BITS-1:0]     fill_y1_i,
    input  logic [COLOR_BITS-1:0] fill_color_i,
    output logic                  fill_busy_o,
    output logic                  fill_done_o,
    output logic                  fill_err_o,
    input  logic                  fb_ready_i,
    output logic [X_BITS-1:0]     addr_x_o,
    output logic [Y_BITS-1:0]     addr_y_o,
    output logic [COLOR_BITS-1:0] color_o,
    output logic                  we_o
);

    fill_state_t state_q;
    xcoord_t     cx_q;
    xcoord_t     x0_q;
    xcoord_t     x1_q;
    ycoord_t     cy_q;
    ycoord_t     y1_q;
    color_t      col_q;
    logic        done_q;
    logic        err_q;

    logic   fill_req_c;
    logic   fill_gnt_c;
    logic   host_gnt_c;
    pixel_t host_pix_c;
    pixel_t fill_pix_c;
    pixel_t slot_pix;

    // Abort withdraws the fill request so no further pixel can be granted.
    always_comb begin
        fill_req_c = (state_q == RUN) && !fill_abort_i;
        host_pix_c = '{x: host_x_i, y: host_y_i, color: host_color_i};
        fill_pix_c = '{x: cx_q, y: cy_q, color: col_q};
    end

    vga_wr_arb u_arb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .host_req_i   (host_req_i),
        .host_pix_i   (host_pix_c),
        .fill_req_i   (fill_req_c),
        .fill_pix_i   (fill_pix_c),
        .fb_ready_i   (fb_ready_i),
        .host_gnt_c_o (host_gnt_c),
        .fill_gnt_c_o (fill_gnt_c),
        .pix_o        (slot_pix),
        .we_o         (we_o)
    );

    // Fill engine walks the rectangle in raster order, one pixel per grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fill_start_i) begin
                        if (rect_legal(fill_x0_i, fill_x1_i, fill_y0_i, fill_y1_i)) begin
                            x0_q    <= fill_x0_i;
                            x1_q    <= fill_x1_i;
                            y1_q    <= fill_y1_i;
                            col_q   <= fill_color_i;
                            cx_q    <= fill_x0_i;
                            cy_q    <= fill_y0_i;
                            state_q <= RUN;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fill_abort_i) begin
                        state_q <= IDLE;
                    end else if (fill_gnt_c) begin
                        if (cx_q < x1_q) begin
                            cx_q <= cx_q + X_BITS'(1);
                        end else begin
                            cx_q <= x0_q;
                            if (cy_q == y1_q) begin
                                state_q <= IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                cy_q <= cy_q + Y_BITS'(1);
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign host_ack_o  = host_gnt_c;
    assign fill_busy_o = (state_q == RUN);
    assign fill_done_o = done_q;
    assign fill_err_o  = err_q;
    assign addr_x_o    = slot_pix.x;
    assign addr_y_o    = slot_pix.y;
    assign color_o     = slot_pix.color;

endmodule

// File: tb/tb_vga_fb_write_ctrl.sv
// Self-checking bench for vga_fb_write_ctrl: start-legality table, directed
// multi-cycle sequences and a randomized run against a raster-order model.
module tb_vga_fb_write_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        host_req_i;
    logic [10:0] host_x_i;
    logic [10:0] host_y_i;
    logic [1:0]  host_color_i;
    logic        host_ack_o;
    logic        fill_start_i;
    logic        fill_abort_i;
    logic [10:0] fill_x0_i;
    logic [10:0] fill_x1_i;
    logic [10:0] fill_y0_i;
    logic [10:0] fill_y1_i;
    logic [1:0]  fill_color_i;
    logic        fill_busy_o;
    logic        fill_done_o;
    logic        fill_err_o;
    logic        fb_ready_i;
    logic [10:0] addr_x_o;
    logic [10:0] addr_y_o;
    logic [1:0]  color_o;
    logic        we_o;

    vga_fb_write_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .host_req_i   (host_req_i),
        .host_x_i     (host_x_i),
        .host_y_i     (host_y_i),
        .host_color_i (host_color_i),
        .host_ack_o   (host_ack_o),
        .fill_start_i (fill_start_i),
        .fill_abort_i (fill_abort_i),
        .fill_x0_i    (fill_x0_i),
        .fill_x1_i    (fill_x1_i),
        .fill_y0_i    (fill_y0_i),
        .fill_y1_i    (fill_y1_i),
        .fill_color_i (fill_color_i),
        .fill_busy_o  (fill_busy_o),
        .fill_done_o  (fill_done_o),
        .fill_err_o   (fill_err_o),
        .fb_ready_i   (fb_ready_i),
        .addr_x_o     (addr_x_o),
        .addr_y_o     (addr_y_o),
        .color_o      (color_o),
        .we_o         (we_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks;
    int n_err;

    typedef struct { int x; int y; int c; } px_t;
    typedef struct { int x0; int x1; int y0; int y1; int c; int err; } start_vec_t;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Stalled slot must keep its request and payload until accepted.
    bit hold_prev;
    int prev_pix;
    always @(negedge clk_i) begin
        if (hold_prev) begin
            chk("hold_we", int'(we_o), 1);
            chk("hold_pix", int'({addr_x_o, addr_y_o, color_o}), prev_pix);
        end
        hold_prev = we_o && !fb_ready_i && !rst_i;
        prev_pix  = int'({addr_x_o, addr_y_o, color_o});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        n_err++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic start_fill(input int x0, input int x1, input int y0, input int y1, input int c);
        fill_x0_i    = 11'(x0);
        fill_x1_i    = 11'(x1);
        fill_y0_i    = 11'(y0);
        fill_y1_i    = 11'(y1);
        fill_color_i = 2'(c);
        fill_start_i = 1'b1;
        @(posedge clk_i); #1;
        fill_start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic chk_pix(string name, int x, int y, int c);
        chk({name, "_we"}, int'(we_o), 1);
        chk({name, "_x"}, int'(addr_x_o), x);
        chk({name, "_y"}, int'(addr_y_o), y);
        chk({name, "_c"}, int'(color_o), c);
    endtask

    start_vec_t tbl[7];
    px_t        exp_s[5];
    px_t        hq[$];
    px_t        fq[$];
    px_t        got[$];
    px_t        p;
    int         acks;
    int         done_n;

    initial begin
        tbl[0] = '{10, 5, 0, 0, 1, 1};
        tbl[1] = '{0, 1280, 0, 0, 1, 1};
        tbl[2] = '{0, 0, 5, 3, 2, 1};
        tbl[3] = '{0, 0, 0, 1024, 2, 1};
        tbl[4] = '{1279, 1279, 1023, 1023, 3, 0};
        tbl[5] = '{0, 0, 0, 0, 1, 0};
        tbl[6] = '{5, 5, 7, 7, 2, 0};

        rst_i = 1'b1; host_req_i = 1'b0; host_x_i = '0; host_y_i = '0; host_color_i = '0;
        fill_start_i = 1'b0; fill_abort_i = 1'b0; fill_x0_i = '0; fill_x1_i = '0;
        fill_y0_i = '0; fill_y1_i = '0; fill_color_i = '0; fb_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_we", int'(we_o), 0);
        chk("rst_addr", int'({addr_x_o, addr_y_o, color_o}), 0);
        chk("rst_flags", int'({host_ack_o, fill_busy_o, fill_done_o, fill_err_o}), 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        idle(1);

        // Start legality: errors pulse once, legal 1x1 writes and completes at T+2.
        for (int i = 0; i < 7; i++) begin
            start_fill(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, tbl[i].c);
            @(negedge clk_i);
            chk($sformatf("tbl%0d_err_t1", i), int'(fill_err_o), tbl[i].err);
            chk($sformatf("tbl%0d_busy_t1", i), int'(fill_busy_o), 1 - tbl[i].err);
            chk($sformatf("tbl%0d_we_t1", i), int'(we_o), 0);
            @(negedge clk_i);
            chk($sformatf("tbl%0d_we_t2", i), int'(we_o), 1 - tbl[i].err);
            chk($sformatf("tbl%0d_done_t2", i), int'(fill_done_o), 1 - tbl[i].err);
            chk($sformatf("tbl%0d_err_t2", i), int'(fill_err_o), 0);
            if (tbl[i].err == 0) chk_pix($sformatf("tbl%0d_pix", i), tbl[i].x0, tbl[i].y0, tbl[i].c);
            @(posedge clk_i); #1;
            idle(2);
            chk($sformatf("tbl%0d_idle_busy", i), int'(fill_busy_o), 0);
        end

        // 2x2 fill, free-running framebuffer.
        exp_s[0] = '{0, 0, 3}; exp_s[1] = '{1, 0, 3}; exp_s[2] = '{0, 1, 3}; exp_s[3] = '{1, 1, 3};
        start_fill(0, 1, 0, 1, 3);
        @(negedge clk_i);
        chk("f22_busy_t1", int'(fill_busy_o), 1);
        chk("f22_we_t1", int'(we_o), 0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk_i);
            chk_pix($sformatf("f22_c%0d", c), exp_s[c-2].x, exp_s[c-2].y, exp_s[c-2].c);
            chk($sformatf("f22_done_c%0d", c), int'(fill_done_o), int'(c == 5));
        end
        @(negedge clk_i);
        chk("f22_busy_end", int'(fill_busy_o), 0);
        chk("f22_we_end", int'(we_o), 0);
        chk("f22_done_end", int'(fill_done_o), 0);
        idle(2);

        // Host and fill tie on the first RUN cycle: host goes first.
        exp_s[0] = '{100, 200, 1}; exp_s[1] = '{0, 0, 3}; exp_s[2] = '{1, 0, 3};
        exp_s[3] = '{0, 1, 3};     exp_s[4] = '{1, 1, 3};
        start_fill(0, 1, 0, 1, 3);
        host_req_i = 1'b1; host_x_i = 11'd100; host_y_i = 11'd200; host_color_i = 2'd1;
        acks = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i);
            acks += int'(host_ack_o);
            if (c == 1) chk("arb_ack_c1", int'(host_ack_o), 1);
            if (c >= 2) begin
                chk_pix($sformatf("arb_c%0d", c), exp_s[c-2].x, exp_s[c-2].y, exp_s[c-2].c);
                chk($sformatf("arb_done_c%0d", c), int'(fill_done_o), int'(c == 6));
            end
            @(posedge clk_i); #1;
            if (acks > 0) host_req_i = 1'b0;
        end
        chk("arb_ack_count", acks, 1);
        idle(2);

        // Five-cycle backpressure in the middle of a fill.
        got.delete(); done_n = 0;
        start_fill(1, 2, 3, 4, 2);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk_i);
            if (we_o && fb_ready_i) got.push_back('{int'(addr_x_o), int'(addr_y_o), int'(color_o)});
            done_n += int'(fill_done_o);
            if (cyc >= 3 && cyc <= 7) chk($sformatf("stall_we_c%0d", cyc), int'(we_o), 1);
            @(posedge clk_i); #1;
            fb_ready_i = !((cyc + 1) >= 3 && (cyc + 1) <= 7);
        end
        exp_s[0] = '{1, 3, 2}; exp_s[1] = '{2, 3, 2}; exp_s[2] = '{1, 4, 2}; exp_s[3] = '{2, 4, 2};
        chk("stall_nwrites", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            chk($sformatf("stall_w%0d_x", i), got[i].x, exp_s[i].x);
            chk($sformatf("stall_w%0d_y", i), got[i].y, exp_s[i].y);
            chk($sformatf("stall_w%0d_c", i), got[i].c, exp_s[i].c);
        end
        chk("stall_done", done_n, 1);

        // Abort of an 8x1 fill after three pixels, then an immediate restart.
        start_fill(0, 7, 5, 5, 1);
        @(negedge clk_i);
        @(posedge clk_i); #1;
        @(negedge clk_i); chk_pix("abt_c2", 0, 5, 1);
        @(posedge clk_i); #1;
        @(negedge clk_i); chk_pix("abt_c3", 1, 5, 1);
        @(posedge clk_i); #1;
        fill_abort_i = 1'b1;
        @(negedge clk_i);
        chk_pix("abt_c4", 2, 5, 1);
        chk("abt_busy_c4", int'(fill_busy_o), 1);
        @(posedge clk_i); #1;
        fill_abort_i = 1'b0;
        fill_x0_i = 11'd20; fill_x1_i = 11'd20; fill_y0_i = 11'd9; fill_y1_i = 11'd9;
        fill_color_i = 2'd2; fill_start_i = 1'b1;
        @(negedge clk_i);
        chk("abt_we_c5", int'(we_o), 0);
        chk("abt_busy_c5", int'(fill_busy_o), 0);
        chk("abt_done_c5", int'(fill_done_o), 0);
        @(posedge clk_i); #1;
        fill_start_i = 1'b0;
        @(negedge clk_i);
        chk("abt_restart_busy", int'(fill_busy_o), 1);
        @(negedge clk_i);
        chk_pix("abt_restart_pix", 20, 9, 2);
        chk("abt_restart_done", int'(fill_done_o), 1);
        @(posedge clk_i); #1;
        idle(2);

        // Reset while the slot holds a host write; afterwards the host wins a tie.
        start_fill(0, 3, 6, 6, 1);
        host_req_i = 1'b1; host_x_i = 11'd300; host_y_i = 11'd301; host_color_i = 2'd2;
        fb_ready_i = 1'b0;
        @(negedge clk_i);
        chk("rsm_ack_c1", int'(host_ack_o), 1);
        @(posedge clk_i); #1;
        host_req_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        chk_pix("rsm_slot_c2", 300, 301, 2);
        @(posedge clk_i); #1;
        rst_i = 1'b0; fb_ready_i = 1'b1;
        fill_x0_i = 11'd7; fill_x1_i = 11'd7; fill_y0_i = 11'd8; fill_y1_i = 11'd8;
        fill_color_i = 2'd3; fill_start_i = 1'b1;
        @(negedge clk_i);
        chk("rsm_we", int'(we_o), 0);
        chk("rsm_addr", int'({addr_x_o, addr_y_o, color_o}), 0);
        chk("rsm_flags", int'({host_ack_o, fill_busy_o, fill_done_o, fill_err_o}), 0);
        @(posedge clk_i); #1;
        fill_start_i = 1'b0;
        host_req_i = 1'b1; host_x_i = 11'd400; host_y_i = 11'd401; host_color_i = 2'd3;
        @(negedge clk_i);
        chk("rsm_busy", int'(fill_busy_o), 1);
        chk("rsm_host_first", int'(host_ack_o), 1);
        @(posedge clk_i); #1;
        host_req_i = 1'b0;
        @(negedge clk_i);
        chk_pix("rsm_host_pix", 400, 401, 3);
        @(negedge clk_i);
        chk_pix("rsm_fill_pix", 7, 8, 3);
        @(posedge clk_i); #1;
        idle(2);

        // Randomized: random rectangles, host traffic in x>=640 and random backpressure.
        for (int it = 0; it < 40; it++) begin
            int w, h, x0, y0, c, hl, steps;
            bit ackf;
            w  = int'($urandom_range(1, 6));
            h  = int'($urandom_range(1, 4));
            x0 = int'($urandom_range(0, 600));
            y0 = int'($urandom_range(0, 1020));
            c  = int'($urandom_range(0, 3));
            fq.delete(); hq.delete();
            for (int yy = y0; yy < y0 + h; yy++)
                for (int xx = x0; xx < x0 + w; xx++)
                    fq.push_back('{xx, yy, c});
            fb_ready_i = 1'b1;
            start_fill(x0, x0 + w - 1, y0, y0 + h - 1, c);
            hl = int'($urandom_range(0, 5));
            done_n = 0; ackf = 1'b0; steps = 0;
            while (steps < 400 && !(fq.size() == 0 && hq.size() == 0 && hl == 0 && !host_req_i)) begin
                @(negedge clk_i);
                steps++;
                if (we_o && fb_ready_i) begin
                    if (int'(addr_x_o) >= 640) begin
                        chk("rnd_host_expected", int'(hq.size() > 0), 1);
                        if (hq.size() > 0) begin
                            p = hq.pop_front();
                            chk("rnd_host_x", int'(addr_x_o), p.x);
                            chk("rnd_host_y", int'(addr_y_o), p.y);
                            chk("rnd_host_c", int'(color_o), p.c);
                        end
                    end else begin
                        chk("rnd_fill_expected", int'(fq.size() > 0), 1);
                        if (fq.size() > 0) begin
                            p = fq.pop_front();
                            chk("rnd_fill_x", int'(addr_x_o), p.x);
                            chk("rnd_fill_y", int'(addr_y_o), p.y);
                            chk("rnd_fill_c", int'(color_o), p.c);
                        end
                    end
                end
                if (host_ack_o) ackf = 1'b1;
                done_n += int'(fill_done_o);
                @(posedge clk_i); #1;
                fb_ready_i = ($urandom_range(0, 3) != 0);
                if (ackf) begin host_req_i = 1'b0; ackf = 1'b0; end
                if (!host_req_i && hl > 0 && $urandom_range(0, 2) == 0) begin
                    p = '{int'($urandom_range(640, 1279)), int'($urandom_range(0, 1023)),
                          int'($urandom_range(0, 3))};
                    host_x_i = 11'(p.x); host_y_i = 11'(p.y); host_color_i = 2'(p.c);
                    host_req_i = 1'b1;
                    hq.push_back(p);
                    hl--;
                end
            end
            chk($sformatf("rnd%0d_timeout", it), int'(steps < 400), 1);
            chk($sformatf("rnd%0d_fill_left", it), fq.size(), 0);
            chk($sformatf("rnd%0d_host_left", it), hq.size(), 0);
            chk($sformatf("rnd%0d_done", it), done_n, 1);
            fb_ready_i = 1'b1; host_req_i = 1'b0;
            @(negedge clk_i);
            chk($sformatf("rnd%0d_busy_end", it), int'(fill_busy_o), 0);
            @(posedge clk_i); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
